l2a_request_responder: RTL and testbench

L2a-side responder for the L1a↔L2a request protocol. It serves L1a line-fill reads, inclusion-policy word writes and dirty-line write-backs from a direct-mapped L2a line store. On a miss it evicts to main memory and refills from main memory through a held req/ready handshake. It sits between the L1a cache FSM and the main-memory model.

---
 rtl/cache_config.sv | 15 +
 rtl/l2a_request_responder_if.sv | 44 ++++
 rtl/l2a_line_store.sv | 46 ++++
 rtl/l2a_request_responder.sv | 152 +++++++++++++++
 tb/tb_l2a_request_responder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cache_config.sv
// cache_config: shared FSM/opcode types and L2a address-geometry helpers.
package cache_config;

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, UPDATE, RESPOND} l2a_state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_WRITE_BACK} l2a_op_t;

    // Stored tag keeps the processor ID bits on top of the plain address tag.
    function automatic int l2_tag_width(int aw, int pw, int iw, int ow);
        return pw + (aw - pw - iw - ow - 2);
    endfunction

    localparam int L2_TAG_WIDTH = l2_tag_width(32, 2, 6, 2);
    localparam int L2_SETS      = 1 << 6;

endpackage

// File: rtl/l2a_request_responder_if.sv
// l2a_request_responder_if: L1a request side plus main-memory side of the L2a responder.
interface l2a_request_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LINE_WIDTH    = 128
);
    logic                     read_from_L2a_request;
    logic                     write_to_L2a_request;
    logic                     write_back_to_L2a_request;
    logic [ADDRESS_WIDTH-1:0] cache_L2a_memory_address;
    logic [DATA_WIDTH-1:0]    cache_1a_write_data_to_L2a;
    logic [LINE_WIDTH-1:0]    write_back_to_L2a_data;
    logic                     L2a_ready;
    logic [LINE_WIDTH-1:0]    write_data_to_L1a_from_L2a;
    logic                     write_to_L2a_verified;
    logic                     write_back_to_L2a_verified;
    logic                     L2a_cache_hit;
    logic                     L2a_cache_miss;
    logic                     mem_read_request;
    logic                     mem_write_request;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0]    mem_write_data;
    logic [LINE_WIDTH-1:0]    mem_read_data;
    logic                     mem_ready;

    modport slave (
        input  read_from_L2a_request, write_to_L2a_request, write_back_to_L2a_request,
               cache_L2a_memory_address, cache_1a_write_data_to_L2a, write_back_to_L2a_data,
               mem_read_data, mem_ready,
        output L2a_ready, write_data_to_L1a_from_L2a, write_to_L2a_verified,
               write_back_to_L2a_verified, L2a_cache_hit, L2a_cache_miss,
               mem_read_request, mem_write_request, mem_address, mem_write_data
    );

    modport master (
        output read_from_L2a_request, write_to_L2a_request, write_back_to_L2a_request,
               cache_L2a_memory_address, cache_1a_write_data_to_L2a, write_back_to_L2a_data,
               mem_read_data, mem_ready,
        input  L2a_ready, write_data_to_L1a_from_L2a, write_to_L2a_verified,
               write_back_to_L2a_verified, L2a_cache_hit, L2a_cache_miss,
               mem_read_request, mem_write_request, mem_address, mem_write_data
    );

endinterface

// File: rtl/l2a_line_store.sv
// l2a_line_store: direct-mapped valid/dirty/tag/line arrays, combinational read, one write port.
module l2a_line_store #(
    parameter int IW = 6,
    parameter int TW = 22,
    parameter int LW = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] idx_i,
    input  logic          valid_we_i,
    input  logic          valid_i,
    input  logic          dirty_we_i,
    input  logic          dirty_i,
    input  logic          tag_we_i,
    input  logic [TW-1:0] tag_i,
    input  logic          line_we_i,
    input  logic [LW-1:0] line_i,
    output logic          valid_o,
    output logic          dirty_o,
    output logic [TW-1:0] tag_o,
    output logic [LW-1:0] line_o
);
    logic [(1<<IW)-1:0] valid_q, dirty_q;
    logic [TW-1:0]      tag_q  [1<<IW];
    logic [LW-1:0]      line_q [1<<IW];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = line_q[idx_i];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '{default: '0};
            line_q  <= '{default: '0};
        end else begin
            if (valid_we_i) valid_q[idx_i] <= valid_i;
            if (dirty_we_i) dirty_q[idx_i] <= dirty_i;
            if (tag_we_i)   tag_q[idx_i]   <= tag_i;
            if (line_we_i)  line_q[idx_i]  <= line_i;
        end
    end

endmodule

// File: rtl/l2a_request_responder.sv
// l2a_request_responder: L2a-side responder serving L1a fills, word writes and write-backs
// from a direct-mapped store, evicting/refilling through main memory on a miss.
module l2a_request_responder
    import cache_config::*;
#(
    parameter int ADDRESS_WIDTH      = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int LINE_WIDTH         = 128,
    parameter int PROCESSOR_ID_WIDTH = 2,
    parameter int L2_INDEX_WIDTH     = 6,
    parameter int WORD_OFFSET_WIDTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    l2a_request_responder_if.slave   bus
);
    localparam int LSB = WORD_OFFSET_WIDTH + 2;
    localparam int IW  = L2_INDEX_WIDTH;
    localparam int TW  = l2_tag_width(ADDRESS_WIDTH, PROCESSOR_ID_WIDTH, L2_INDEX_WIDTH, WORD_OFFSET_WIDTH);

    l2a_state_t               state_q;
    l2a_op_t                  op_q, op_n;
    logic [ADDRESS_WIDTH-1:2] addr_q;
    logic [DATA_WIDTH-1:0]    word_q;
    logic [LINE_WIDTH-1:0]    wb_line_q, rdata_q, mem_wdata_q, merged, line_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic ready_q, wr_ok_q, wb_ok_q, hit_q, miss_q, mem_rd_q, mem_wr_q;
    logic [IW-1:0]            cur_idx;
    logic [TW-1:0]            cur_tag, st_tag;
    logic [LINE_WIDTH-1:0]    st_line;
    logic st_valid, st_dirty, hit, any_req, ev_done, fill_done, upd;
    logic valid_we, dirty_we, line_we;

    // In IDLE the store is looked up with the incoming address so hit/miss can pulse during LOOKUP.
    assign cur_idx   = (state_q == IDLE) ? bus.cache_L2a_memory_address[LSB+IW-1:LSB] : addr_q[LSB+IW-1:LSB];
    assign cur_tag   = (state_q == IDLE) ? bus.cache_L2a_memory_address[ADDRESS_WIDTH-1:LSB+IW] : addr_q[ADDRESS_WIDTH-1:LSB+IW];
    assign hit       = st_valid && (st_tag == cur_tag);
    assign any_req   = bus.write_back_to_L2a_request | bus.write_to_L2a_request | bus.read_from_L2a_request;
    assign op_n      = bus.write_back_to_L2a_request ? OP_WRITE_BACK : bus.write_to_L2a_request ? OP_WRITE : OP_READ;
    assign ev_done   = (state_q == EVICT) && mem_wr_q && bus.mem_ready;
    assign fill_done = (state_q == FILL) && mem_rd_q && bus.mem_ready;
    assign upd       = state_q == UPDATE;
    assign valid_we  = fill_done | (upd && op_q == OP_WRITE_BACK);
    assign dirty_we  = ev_done | fill_done | (upd && op_q != OP_READ);
    assign line_we   = fill_done | (upd && op_q != OP_READ);
    assign line_d    = fill_done ? bus.mem_read_data : (op_q == OP_WRITE_BACK) ? wb_line_q : merged;

    always_comb begin
        merged = st_line;
        merged[addr_q[LSB-1:2]*DATA_WIDTH +: DATA_WIDTH] = word_q;
    end

    l2a_line_store #(.IW(IW), .TW(TW), .LW(LINE_WIDTH)) u_store (
        .clk        (clk),
        .reset      (reset),
        .idx_i      (cur_idx),
        .valid_we_i (valid_we),
        .valid_i    (1'b1),
        .dirty_we_i (dirty_we),
        .dirty_i    (upd),
        .tag_we_i   (valid_we),
        .tag_i      (cur_tag),
        .line_we_i  (line_we),
        .line_i     (line_d),
        .valid_o    (st_valid),
        .dirty_o    (st_dirty),
        .tag_o      (st_tag),
        .line_o     (st_line)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            word_q      <= '0;
            wb_line_q   <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ready_q     <= 1'b0;
            wr_ok_q     <= 1'b0;
            wb_ok_q     <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            wr_ok_q <= 1'b0;
            wb_ok_q <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            case (state_q)
                IDLE: if (any_req) begin
                    state_q   <= LOOKUP;
                    op_q      <= op_n;
                    addr_q    <= bus.cache_L2a_memory_address[ADDRESS_WIDTH-1:2];
                    word_q    <= bus.cache_1a_write_data_to_L2a;
                    wb_line_q <= bus.write_back_to_L2a_data;
                    hit_q     <= hit;
                    miss_q    <= !hit;
                end
                LOOKUP: if (hit) state_q <= UPDATE;
                else if (st_valid && st_dirty) begin
                    state_q     <= EVICT;
                    mem_wr_q    <= 1'b1;
                    mem_addr_q  <= {st_tag, cur_idx, {LSB{1'b0}}};
                    mem_wdata_q <= st_line;
                end else if (op_q == OP_WRITE_BACK) state_q <= UPDATE;
                else begin
                    state_q    <= FILL;
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= {cur_tag, cur_idx, {LSB{1'b0}}};
                end
                EVICT: if (ev_done) begin
                    mem_wr_q <= 1'b0;
                    if (op_q == OP_WRITE_BACK) state_q <= UPDATE;
                    else begin
                        state_q    <= FILL;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= {cur_tag, cur_idx, {LSB{1'b0}}};
                    end
                end
                FILL: if (fill_done) begin
                    mem_rd_q <= 1'b0;
                    state_q  <= UPDATE;
                end
                UPDATE: begin
                    state_q <= RESPOND;
                    if (op_q == OP_READ) rdata_q <= st_line;
                    ready_q <= op_q == OP_READ;
                    wr_ok_q <= op_q == OP_WRITE;
                    wb_ok_q <= op_q == OP_WRITE_BACK;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.L2a_ready                  = ready_q;
    assign bus.write_data_to_L1a_from_L2a = rdata_q;
    assign bus.write_to_L2a_verified      = wr_ok_q;
    assign bus.write_back_to_L2a_verified = wb_ok_q;
    assign bus.L2a_cache_hit              = hit_q;
    assign bus.L2a_cache_miss             = miss_q;
    assign bus.mem_read_request           = mem_rd_q;
    assign bus.mem_write_request          = mem_wr_q;
    assign bus.mem_address                = mem_addr_q;
    assign bus.mem_write_data             = mem_wdata_q;

endmodule

// File: tb/tb_l2a_request_responder.sv
// tb_l2a_request_responder: directed vectors with hand-computed expectations for the L2a responder.
module tb_l2a_request_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l2a_request_responder_if bus ();

    l2a_request_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    int hit_n, miss_n, ev_cyc, rd_n, wr_n, resp_cyc, pulse_n, extra_n;
    logic [31:0]  rd_adr, wr_adr;
    logic [127:0] wr_dat;
    logic [2:0]   kinds;

    localparam logic [127:0] LA  = {4{32'hAAAAAAAA}};
    localparam logic [127:0] LM  = {32'hAAAAAAAA, 32'h12345678, 32'hAAAAAAAA, 32'hAAAAAAAA};
    localparam logic [127:0] L5  = {4{32'h55555555}};
    localparam logic [127:0] LWB = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
    localparam logic [127:0] L7  = {4{32'h77777777}};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Present one request, act as main memory (ready after d wait cycles), record what happened.
    task automatic do_req(input logic rd, input logic wr, input logic wb, input logic [31:0] a,
                          input logic [31:0] w, input logic [127:0] l, input logic [127:0] f, input int d);
        int rw, ww;
        rw = 0; ww = 0;
        hit_n = 0; miss_n = 0; ev_cyc = 0; rd_n = 0; wr_n = 0; resp_cyc = 0; pulse_n = 0;
        rd_adr = '0; wr_adr = '0; wr_dat = '0; kinds = '0;
        bus.read_from_L2a_request      = rd;
        bus.write_to_L2a_request       = wr;
        bus.write_back_to_L2a_request  = wb;
        bus.cache_L2a_memory_address   = a;
        bus.cache_1a_write_data_to_L2a = w;
        bus.write_back_to_L2a_data     = l;
        bus.mem_read_data              = f;
        for (int c = 1; c <= 40 && resp_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.L2a_cache_hit) begin hit_n++; ev_cyc = c; end
            if (bus.L2a_cache_miss) begin miss_n++; ev_cyc = c; end
            if (bus.mem_read_request) begin
                if (rd_n == 0) rd_adr = bus.mem_address;
                rd_n++;
            end
            if (bus.mem_write_request) begin
                if (wr_n == 0) begin wr_adr = bus.mem_address; wr_dat = bus.mem_write_data; end
                wr_n++;
            end
            bus.mem_ready = (bus.mem_read_request && rw >= d) || (bus.mem_write_request && ww >= d);
            if (bus.mem_read_request) rw++;
            if (bus.mem_write_request) ww++;
            if (bus.L2a_ready | bus.write_to_L2a_verified | bus.write_back_to_L2a_verified) begin
                resp_cyc = c;
                pulse_n++;
                kinds = {bus.L2a_ready, bus.write_to_L2a_verified, bus.write_back_to_L2a_verified};
            end
        end
        bus.read_from_L2a_request     = 1'b0;
        bus.write_to_L2a_request      = 1'b0;
        bus.write_back_to_L2a_request = 1'b0;
        bus.mem_ready                 = 1'b0;
        extra_n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.L2a_ready | bus.write_to_L2a_verified | bus.write_back_to_L2a_verified |
                bus.L2a_cache_hit | bus.L2a_cache_miss | bus.mem_read_request | bus.mem_write_request)
                extra_n++;
        end
    endtask

    initial begin
        logic seen;
        bus.read_from_L2a_request      = 1'b0;
        bus.write_to_L2a_request       = 1'b0;
        bus.write_back_to_L2a_request  = 1'b0;
        bus.cache_L2a_memory_address   = '0;
        bus.cache_1a_write_data_to_L2a = '0;
        bus.write_back_to_L2a_data     = '0;
        bus.mem_read_data              = '0;
        bus.mem_ready                  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {bus.L2a_ready, bus.write_to_L2a_verified, bus.write_back_to_L2a_verified,
                             bus.L2a_cache_hit, bus.L2a_cache_miss, bus.mem_read_request, bus.mem_write_request}, 0);
        check("reset_mem_addr", bus.mem_address, 0);
        check("reset_rdata", bus.write_data_to_L1a_from_L2a, 0);
        reset = 1'b0;

        // mem_ready with nothing outstanding must do nothing
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_mem_ready", {bus.L2a_ready, bus.mem_read_request, bus.mem_write_request}, 0);
        bus.mem_ready = 1'b0;

        do_req(1, 0, 0, 32'h10, 0, 0, LA, 0);
        check("cold_miss", {hit_n, miss_n, ev_cyc}, {32'd0, 32'd1, 32'd1});
        check("cold_fill_addr", rd_adr, 32'h10);
        check("cold_mem_counts", {rd_n, wr_n}, {32'd1, 32'd0});
        check("cold_resp_cyc", resp_cyc, 4);
        check("cold_kind", {kinds, pulse_n[3:0]}, {3'b100, 4'd1});
        check("cold_line", bus.write_data_to_L1a_from_L2a, LA);
        check("cold_quiet", extra_n, 0);

        do_req(1, 0, 0, 32'h10, 0, 0, L7, 0);
        check("hit_read", {hit_n, miss_n, ev_cyc}, {32'd1, 32'd0, 32'd1});
        check("hit_resp_cyc", resp_cyc, 3);
        check("hit_no_mem", {rd_n, wr_n}, 0);
        check("hit_line", bus.write_data_to_L1a_from_L2a, LA);

        do_req(0, 1, 0, 32'h18, 32'h12345678, 0, L7, 0);
        check("write_hit", {hit_n, miss_n}, {32'd1, 32'd0});
        check("write_kind", kinds, 3'b010);
        check("write_resp_cyc", resp_cyc, 3);
        check("write_no_mem", {rd_n, wr_n}, 0);

        do_req(1, 0, 0, 32'h10, 0, 0, L7, 0);
        check("merged_line", bus.write_data_to_L1a_from_L2a, LM);

        // Dirty victim at index 1, memory answers after one wait cycle
        do_req(1, 0, 0, 32'h410, 0, 0, L5, 1);
        check("dirty_miss", {hit_n, miss_n}, {32'd0, 32'd1});
        check("evict_addr", wr_adr, 32'h10);
        check("evict_data", wr_dat, LM);
        check("evict_fill_cycles", {wr_n, rd_n}, {32'd2, 32'd2});
        check("dirty_fill_addr", rd_adr, 32'h410);
        check("dirty_resp_cyc", resp_cyc, 7);
        check("dirty_line", bus.write_data_to_L1a_from_L2a, L5);

        do_req(1, 0, 1, 32'h820, 0, LWB, L7, 0);
        check("wb_miss", {hit_n, miss_n}, {32'd0, 32'd1});
        check("wb_no_mem", {rd_n, wr_n}, 0);
        check("wb_kind", {kinds, pulse_n[3:0]}, {3'b001, 4'd1});
        check("wb_resp_cyc", resp_cyc, 3);
        check("wb_quiet", extra_n, 0);
        check("rdata_held", bus.write_data_to_L1a_from_L2a, L5);

        do_req(1, 0, 0, 32'h820, 0, 0, L7, 0);
        check("wb_line_hit", {hit_n, rd_n}, {32'd1, 32'd0});
        check("wb_line", bus.write_data_to_L1a_from_L2a, LWB);

        // Reset while FILL waits on memory
        bus.read_from_L2a_request    = 1'b1;
        bus.cache_L2a_memory_address = 32'h10;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = bus.mem_read_request;
        end
        check("rst_fill_entered", seen, 1);
        reset = 1'b1;
        bus.read_from_L2a_request = 1'b0;
        @(negedge clk);
        check("rst_drop_mem", {bus.mem_read_request, bus.mem_write_request}, 0);
        check("rst_no_pulse", {bus.L2a_ready, bus.write_to_L2a_verified, bus.write_back_to_L2a_verified}, 0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | bus.L2a_ready | bus.mem_read_request;
        end
        check("rst_quiet", seen, 0);

        do_req(1, 0, 0, 32'h10, 0, 0, L7, 0);
        check("post_rst_miss", {hit_n, miss_n}, {32'd0, 32'd1});
        check("post_rst_fill", {rd_adr, rd_n}, {32'h10, 32'd1});
        check("post_rst_line", bus.write_data_to_L1a_from_L2a, L7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
